// File: rtl/cic_vco_diff_mc.sv
// Multi-channel differential CIC decimator for VCO-based ADC front ends.
// Per channel: modular phase difference p-m, ORDER pipelined integrators, shared decimation, ORDER combs.
module cic_vco_diff_mc #(
    parameter int BW     = 6,
    parameter int ORDER  = 3,
    parameter int R_LOG2 = 3,
    parameter int CH     = 2,
    localparam int OW    = BW + 1 + ORDER * R_LOG2
) (
    input  logic               CLK,
    input  logic               RES,
    input  logic               ENABLE,
    input  logic [CH*BW-1:0]   IN_P,
    input  logic [CH*BW-1:0]   IN_M,
    output logic [CH*OW-1:0]   OUT,
    output logic               OUT_VALID
);

    localparam int SW = $clog2(ORDER + 1);
    localparam logic [R_LOG2-1:0] CNT_MAX    = {R_LOG2{1'b1}};
    localparam logic [SW-1:0]     SETTLE_MAX = SW'(ORDER);

    logic                r_primed;
    logic [R_LOG2-1:0]   r_dec_cnt;
    logic [SW-1:0]       r_settle;
    logic                r_valid;
    logic [CH*OW-1:0]    r_out;
    logic [BW-1:0]       r_prev_p [CH];
    logic [BW-1:0]       r_prev_m [CH];
    logic [OW-1:0]       r_integ  [CH][ORDER];
    logic [OW-1:0]       r_z      [CH][ORDER];

    logic [OW-1:0]       w_diff   [CH];
    logic [OW-1:0]       w_stage  [CH][ORDER];
    logic [OW-1:0]       w_comb   [CH];
    logic                w_dec;

    // Modular first difference and combinational comb chain per channel
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            logic [BW-1:0] v_dp;
            logic [BW-1:0] v_dm;
            logic [BW:0]   v_d;
            logic [OW-1:0] v_acc;
            v_dp = IN_P[c*BW +: BW] - r_prev_p[c];
            v_dm = IN_M[c*BW +: BW] - r_prev_m[c];
            v_d  = {1'b0, v_dp} - {1'b0, v_dm};
            if (r_primed) begin
                w_diff[c] = {{(OW-BW-1){v_d[BW]}}, v_d};
            end else begin
                w_diff[c] = '0;
            end
            v_acc = r_integ[c][ORDER-1];
            for (int k = 0; k < ORDER; k++) begin
                w_stage[c][k] = v_acc;
                v_acc = v_acc - r_z[c][k];
            end
            w_comb[c] = v_acc;
        end
    end

    assign w_dec = r_primed & (r_dec_cnt == CNT_MAX);

    // Datapath, decimation control and output registers
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            r_primed  <= 1'b0;
            r_dec_cnt <= '0;
            r_settle  <= '0;
            r_valid   <= 1'b0;
            r_out     <= '0;
            for (int c = 0; c < CH; c++) begin
                r_prev_p[c] <= '0;
                r_prev_m[c] <= '0;
                for (int k = 0; k < ORDER; k++) begin
                    r_integ[c][k] <= '0;
                    r_z[c][k]     <= '0;
                end
            end
        end else if (ENABLE) begin
            r_primed <= 1'b1;
            if (r_primed) begin
                r_dec_cnt <= r_dec_cnt + R_LOG2'(1);
            end else begin
                r_dec_cnt <= r_dec_cnt;
            end
            for (int c = 0; c < CH; c++) begin
                r_prev_p[c]   <= IN_P[c*BW +: BW];
                r_prev_m[c]   <= IN_M[c*BW +: BW];
                r_integ[c][0] <= r_integ[c][0] + w_diff[c];
                for (int k = 1; k < ORDER; k++) begin
                    r_integ[c][k] <= r_integ[c][k] + r_integ[c][k-1];
                end
            end
            if (w_dec) begin
                for (int c = 0; c < CH; c++) begin
                    r_out[c*OW +: OW] <= w_comb[c];
                    for (int k = 0; k < ORDER; k++) begin
                        r_z[c][k] <= w_stage[c][k];
                    end
                end
                // Early results are flushed through OUT silently until the combs hold real history
                if (r_settle == SETTLE_MAX) begin
                    r_valid <= 1'b1;
                end else begin
                    r_settle <= r_settle + SW'(1);
                    r_valid  <= 1'b0;
                end
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign OUT       = r_out;
    assign OUT_VALID = r_valid & ENABLE;

endmodule

// File: tb/tb_cic_vco_diff_mc.sv
// Scoreboard bench for cic_vco_diff_mc: directed frequency vectors, expected words queued per strobe.
module tb_cic_vco_diff_mc;

    localparam int BW = 6;
    localparam int CH = 2;
    localparam int OW = 16;

    logic              CLK = 1'b0;
    logic              RES;
    logic              ENABLE;
    logic [CH*BW-1:0]  IN_P;
    logic [CH*BW-1:0]  IN_M;
    logic [CH*OW-1:0]  OUT;
    logic              OUT_VALID;

    cic_vco_diff_mc dut (
        .CLK       (CLK),
        .RES       (RES),
        .ENABLE    (ENABLE),
        .IN_P      (IN_P),
        .IN_M      (IN_M),
        .OUT       (OUT),
        .OUT_VALID (OUT_VALID)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        chk;
        logic [15:0] e0;
        logic [15:0] e1;
    } exp_t;

    exp_t        q[$];
    int          n_vec    = 0;
    int          n_err    = 0;
    int          n_strobe = 0;
    int          n_pushed = 0;
    logic [5:0]  ph_p [CH];
    logic [5:0]  ph_m [CH];
    int          fp [CH];
    int          fm [CH];

    task automatic check16(input string name, input logic [15:0] got, input logic [15:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%h) want %0d (0x%h)", name, $signed(got), got, $signed(want), want);
        end
    endtask

    task automatic set_freq(input int p0, input int m0, input int p1, input int m1);
        fp[0] = p0; fm[0] = m0;
        fp[1] = p1; fm[1] = m1;
    endtask

    task automatic push(input int nskip, input int nchk, input logic [15:0] e0, input logic [15:0] e1);
        exp_t e;
        for (int i = 0; i < nskip + nchk; i++) begin
            e.chk = (i >= nskip);
            e.e0  = e0;
            e.e1  = e1;
            q.push_back(e);
            n_pushed++;
        end
    endtask

    task automatic drive_cycle(input logic en);
        ENABLE = en;
        for (int c = 0; c < CH; c++) begin
            IN_P[c*BW +: BW] = ph_p[c];
            IN_M[c*BW +: BW] = ph_m[c];
        end
        @(posedge CLK);
        #1;
        if (en) begin
            for (int c = 0; c < CH; c++) begin
                ph_p[c] = ph_p[c] + 6'(fp[c]);
                ph_m[c] = ph_m[c] + 6'(fm[c]);
            end
        end
    endtask

    task automatic run_en(input int edges, input bit rnd);
        int   done;
        int   guard;
        logic en;
        done  = 0;
        guard = 0;
        while (done < edges && guard < 20000) begin
            en = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            drive_cycle(en);
            if (en) done++;
            guard++;
        end
        if (done < edges) begin
            n_vec++;
            n_err++;
            $display("FAIL run_budget: enabled edges %0d required %0d", done, edges);
        end
    endtask

    // Monitor: pop one expectation per strobe and compare both channels
    always @(negedge CLK) begin
        exp_t e;
        if (RES === 1'b1) begin
            if (OUT_VALID === 1'b1 && ENABLE !== 1'b1) begin
                n_err++;
                $display("FAIL valid_while_disabled: OUT_VALID=%b ENABLE=%b", OUT_VALID, ENABLE);
            end
            if (OUT_VALID === 1'b1) begin
                n_strobe++;
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_strobe: OUT=0x%h with no expectation queued", OUT);
                end else begin
                    e = q.pop_front();
                    if (e.chk) begin
                        check16("out_ch0", OUT[15:0], e.e0);
                        check16("out_ch1", OUT[31:16], e.e1);
                    end
                end
            end
        end
    end

    initial begin
        RES    = 1'b0;
        ENABLE = 1'b0;
        IN_P   = '0;
        IN_M   = '0;
        for (int c = 0; c < CH; c++) begin
            ph_p[c] = 6'd0;
            ph_m[c] = 6'd0;
        end
        set_freq(0, 0, 0, 0);
        repeat (3) @(posedge CLK);
        #1;
        check16("reset_out_ch0", OUT[15:0], 16'd0);
        check16("reset_out_ch1", OUT[31:16], 16'd0);
        check16("reset_valid", {15'd0, OUT_VALID}, 16'd0);
        RES = 1'b1;

        // DC 5-0 after reset: prime + 3 suppressed decimations, then exact 5*512
        set_freq(5, 0, 5, 0);
        push(0, 3, 16'd2560, 16'd2560);
        run_en(49, 1'b0);

        // Negative step and equal frequencies (both phases wrap together)
        set_freq(0, 5, 17, 17);
        push(4, 2, 16'hF600, 16'h0000);
        run_en(48, 1'b0);

        // Full-scale extremes
        set_freq(63, 0, 0, 63);
        push(4, 2, 16'h7E00, 16'h8200);
        run_en(48, 1'b0);

        // Channel independence under random ENABLE gaps
        set_freq(5, 0, 0, 3);
        push(4, 4, 16'd2560, 16'hFA00);
        run_en(64, 1'b1);

        // Partial next frame, then asynchronous reset mid-frame
        push(0, 1, 16'd2560, 16'hFA00);
        run_en(12, 1'b0);
        #2;
        RES = 1'b0;
        #1;
        check16("midreset_out_ch0", OUT[15:0], 16'd0);
        check16("midreset_out_ch1", OUT[31:16], 16'd0);
        check16("midreset_valid", {15'd0, OUT_VALID}, 16'd0);
        ENABLE = 1'b0;
        n_pushed = n_pushed - q.size();
        q.delete();
        repeat (2) @(posedge CLK);
        #1;
        RES = 1'b1;

        // Priming and settle repeat after the mid-frame reset
        push(0, 3, 16'd2560, 16'hFA00);
        run_en(49, 1'b0);
        run_en(4, 1'b0);
        ENABLE = 1'b0;
        repeat (2) @(posedge CLK);
        #1;

        check16("strobe_count", 16'(n_strobe), 16'(n_pushed));
        check16("queue_drained", 16'(q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
